// File: rtl/dm_access_unit_if.sv
// Data-memory bus between dm_access_unit (master) and the memory (slave).
// Carries the registered request/write-enable/address/lane signals and the
// grant, read-valid and read-data responses.
interface dm_access_unit_if;
  logic        dm_req;
  logic        dm_we;
  logic [29:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata
  );
endinterface

// File: rtl/dm_access_unit.sv
// MEM-stage data-memory access unit. It turns a load/store from the EXE/MEM
// register into a req/gnt/rvalid bus transaction, stalls the pipeline while
// the access is in flight, places store data on byte lanes and extends load
// data.
// Optional feature: define DM_MISALIGN_CHECK_EN to add the misalign output
// and skip the bus for misaligned half/word accesses.
module dm_access_unit (
  input  logic             clk,
  input  logic             rst,
  input  logic             MEM_DmWr,
  input  logic [1:0]       MEM_WbSel,
  input  logic [31:0]      MEM_AluOut,
  input  logic [31:0]      MEM_OutB,
  input  logic [1:0]       MEM_SaveType,
  input  logic [31:0]      MEM_Instr,
  dm_access_unit_if.master dm,
  output logic             mem_stall,
  output logic [31:0]      MEM_LoadData,
  output logic             MEM_LoadValid
`ifdef DM_MISALIGN_CHECK_EN
  ,
  output logic             misalign
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  typedef enum logic [2:0] {LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW} load_t;

  state_t      state, state_next;
  load_t       ld_type, ld_type_q;
  logic        is_store, is_load, op_valid, skip_req;
  logic        is_load_q;
  logic [1:0]  lo_addr_q;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;
  logic        unused_instr;

  // A store wins when both the store and load markers are set.
  assign is_store     = MEM_DmWr;
  assign is_load      = !MEM_DmWr && (MEM_WbSel == 2'b01);
  assign op_valid     = is_store || is_load;
  assign unused_instr = ^MEM_Instr[25:0];

  // Stall while an access is pending or in flight; never during reset.
  assign mem_stall = !rst && ((state == REQ) || (state == WAIT) ||
                              ((state == IDLE) && op_valid));

  // Decode the load flavour from the opcode; unknown opcodes behave as lw.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no latch.
    ld_type = LD_LW;
    case (MEM_Instr[31:26])
      6'h20:   ld_type = LD_LB;
      6'h24:   ld_type = LD_LBU;
      6'h21:   ld_type = LD_LH;
      6'h25:   ld_type = LD_LHU;
      default: ld_type = LD_LW;
    endcase
  end

`ifdef DM_MISALIGN_CHECK_EN
  // Flag half accesses on odd addresses and word accesses off a word boundary.
  always_comb begin
    skip_req = 1'b0;
    if (is_store) begin
      case (MEM_SaveType)
        2'b00:   skip_req = |MEM_AluOut[1:0];
        2'b01:   skip_req = MEM_AluOut[0];
        default: skip_req = 1'b0;
      endcase
    end else if (is_load) begin
      case (ld_type)
        LD_LH, LD_LHU: skip_req = MEM_AluOut[0];
        LD_LW:         skip_req = |MEM_AluOut[1:0];
        default:       skip_req = 1'b0;
      endcase
    end
  end
`else
  assign skip_req = 1'b0;
`endif

  // Store byte enables and lane-replicated write data.
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = MEM_OutB;
    case (MEM_SaveType)
      2'b00: st_be = 4'b1111;
      2'b01: begin
        st_be    = MEM_AluOut[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{MEM_OutB[15:0]}};
      end
      2'b10: begin
        st_be    = 4'b0001 << MEM_AluOut[1:0];
        st_wdata = {4{MEM_OutB[7:0]}};
      end
      default: st_be = 4'b0000;
    endcase
  end

  // Pick the addressed byte/half of the read word and extend it.
  always_comb begin
    rd_byte = dm.dm_rdata[7:0];
    case (lo_addr_q)
      2'd1:    rd_byte = dm.dm_rdata[15:8];
      2'd2:    rd_byte = dm.dm_rdata[23:16];
      2'd3:    rd_byte = dm.dm_rdata[31:24];
      default: rd_byte = dm.dm_rdata[7:0];
    endcase
    rd_half = lo_addr_q[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
    case (ld_type_q)
      LD_LB:   rd_ext = {{24{rd_byte[7]}}, rd_byte};
      LD_LBU:  rd_ext = {24'h0, rd_byte};
      LD_LH:   rd_ext = {{16{rd_half[15]}}, rd_half};
      LD_LHU:  rd_ext = {16'h0, rd_half};
      default: rd_ext = dm.dm_rdata;
    endcase
  end

  // Next-state logic; stray gnt/rvalid only matter in REQ/WAIT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (op_valid) state_next = skip_req ? DONE : REQ;
      REQ:  if (dm.dm_gnt) state_next = is_load_q ? WAIT : DONE;
      WAIT: if (dm.dm_rvalid) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Bus outputs, captured operation and load result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dm.dm_req     <= 1'b0;
      dm.dm_we      <= 1'b0;
      dm.dm_addr    <= '0;
      dm.dm_be      <= '0;
      dm.dm_wdata   <= '0;
      is_load_q     <= 1'b0;
      ld_type_q     <= LD_LW;
      lo_addr_q     <= '0;
      MEM_LoadData  <= '0;
      MEM_LoadValid <= 1'b0;
`ifdef DM_MISALIGN_CHECK_EN
      misalign      <= 1'b0;
`endif
    end else begin
      MEM_LoadValid <= 1'b0;
`ifdef DM_MISALIGN_CHECK_EN
      misalign      <= 1'b0;
`endif
      case (state)
        IDLE: if (op_valid) begin
          dm.dm_req   <= !skip_req;
          dm.dm_we    <= is_store && !skip_req;
          dm.dm_addr  <= MEM_AluOut[31:2];
          dm.dm_be    <= is_store ? st_be : 4'b1111;
          dm.dm_wdata <= is_store ? st_wdata : 32'h0;
          is_load_q   <= is_load;
          ld_type_q   <= ld_type;
          lo_addr_q   <= MEM_AluOut[1:0];
`ifdef DM_MISALIGN_CHECK_EN
          misalign    <= skip_req;
`endif
        end
        REQ: if (dm.dm_gnt) begin
          dm.dm_req <= 1'b0;
          dm.dm_we  <= 1'b0;
        end
        WAIT: if (dm.dm_rvalid) begin
          MEM_LoadData  <= rd_ext;
          MEM_LoadValid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
